// File: rtl/kernel_bram_ctrl.sv
// Purpose: owns the single-port kernel-weight BRAM; bulk-loads all positions from a cfg stream, then serves conv reads.
// Latency: reads return rd_valid/rd_data exactly 1 cycle after rd_gnt; one word per cycle on back-to-back grants.
// Backpressure: cfg_ready only while loading; rd_req stalls (rd_gnt=0) outside READY and when load_start takes priority.
module kernel_bram_ctrl #(
    parameter int KERNEL_WEIGHT_BITS     = 6,
    parameter int KERNEL_SIZE            = 3,
    parameter int IN_CHANNELS            = 6,
    parameter int OUT_CHANNELS           = 6,
    parameter int DATA_WIDTH             = KERNEL_WEIGHT_BITS * OUT_CHANNELS,
    parameter int TOTAL_KERNEL_POSITIONS = IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
    parameter int ADDR_WIDTH             = $clog2(TOTAL_KERNEL_POSITIONS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    output logic                  loaded,
    output logic                  busy,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_data_in,
    input  logic [DATA_WIDTH-1:0] bram_data_out
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_KERNEL_POSITIONS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  rd_pend;
    logic                  oob_q;
    logic                  wr_fire;
    logic                  rd_in_range;

    // BRAM port steering: a write only on a load handshake, a read only on an in-range grant; never both
    always_comb begin
        cfg_ready    = 1'b0;
        wr_fire      = 1'b0;
        rd_gnt       = 1'b0;
        rd_in_range  = 1'b0;
        bram_en      = 1'b0;
        bram_we      = 1'b0;
        bram_addr    = '0;
        bram_data_in = '0;

        cfg_ready   = (state == LOAD);
        wr_fire     = cfg_ready && cfg_valid;
        rd_gnt      = (state == READY) && rd_req && !load_start;
        rd_in_range = (32'(rd_addr) < 32'(TOTAL_KERNEL_POSITIONS));

        if (wr_fire) begin
            bram_en      = 1'b1;
            bram_we      = 1'b1;
            bram_addr    = wr_ptr;
            bram_data_in = cfg_data;
        end else if (rd_gnt && rd_in_range) begin
            bram_en   = 1'b1;
            bram_addr = rd_addr;
        end
    end

    // Read return: the BRAM word arrives the cycle after the grant; out-of-range grants return zero
    always_comb begin
        rd_valid = rd_pend;
        rd_data  = (rd_pend && !oob_q) ? bram_data_out : '0;
    end

    // Load sequencer and read pipeline; the read pipeline keeps running across load_start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            loaded  <= 1'b0;
            busy    <= 1'b0;
            rd_pend <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            rd_pend <= rd_gnt;
            oob_q   <= rd_gnt && !rd_in_range;

            case (state)
                IDLE, READY: begin
                    if (load_start) begin
                        state  <= LOAD;
                        wr_ptr <= '0;
                        loaded <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        // restart from the first address; earlier words are overwritten on the new pass
                        wr_ptr <= '0;
                    end else if (wr_fire) begin
                        if (wr_ptr == LAST_ADDR) begin
                            state  <= READY;
                            loaded <= 1'b1;
                            busy   <= 1'b0;
                        end else begin
                            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_bram_ctrl.sv
// Bench for kernel_bram_ctrl: table-driven read vectors, randomized loads and reads against a reference model.
// Latency: checks combinational outputs mid-cycle and read returns one cycle after each grant.
// Backpressure: cfg_valid is toggled randomly; rd_req is held across a reload to check stalling.
module tb_kernel_bram_ctrl;

    localparam int DW  = 36;
    localparam int AW  = 6;
    localparam int TOT = 54;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [DW-1:0] cfg_data = '0;
    logic          loaded;
    logic          busy;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_data_in;
    logic [DW-1:0] bram_data_out = '0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [64];
    logic [DW-1:0] ref_mem [TOT];

    typedef struct {
        logic          req;
        logic [AW-1:0] addr;
        logic          exp_gnt;
        logic          exp_en;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    kernel_bram_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_start    (load_start),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_data      (cfg_data),
        .loaded        (loaded),
        .busy          (busy),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_gnt        (rd_gnt),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .bram_en       (bram_en),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_data_in  (bram_data_in),
        .bram_data_out (bram_data_out)
    );

    always #5 clk = ~clk;

    // Single-port BRAM with 1-cycle read latency
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_data_in;
            else         bram_data_out  <= mem[bram_addr];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] expect_word(input logic [AW-1:0] a);
        if (32'(a) < TOT) return ref_mem[a];
        return '0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd0);
        chk({tag, "_rd_gnt"}, 64'(rd_gnt), 64'd0);
        chk({tag, "_bram_en"}, 64'(bram_en), 64'd0);
        chk({tag, "_bram_we"}, 64'(bram_we), 64'd0);
        chk({tag, "_bram_addr"}, 64'(bram_addr), 64'd0);
        chk({tag, "_bram_data_in"}, 64'(bram_data_in), 64'd0);
        chk({tag, "_loaded"}, 64'(loaded), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    endtask

    // load_start cycle accepts no config word and grants no read; LOAD follows with loaded cleared
    task automatic start_load();
        load_start = 1'b1;
        cfg_valid  = 1'b1;
        cfg_data   = rnd_word();
        #4;
        chk("start_cfg_ready", 64'(cfg_ready), 64'd0);
        chk("start_bram_we", 64'(bram_we), 64'd0);
        chk("start_rd_gnt", 64'(rd_gnt), 64'd0);
        @(posedge clk); #1;
        load_start = 1'b0;
        cfg_valid  = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_loaded", 64'(loaded), 64'd0);
    endtask

    // Model: the n-th accepted config word lands at address n; the load ends after TOT words
    task automatic run_load(input bit rnd_valid, input bit ramp, input int target);
        int n;
        int cyc;
        n = 0;
        cyc = 0;
        while (n < target && cyc < 2000) begin
            cfg_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_data  = ramp ? DW'(n * 3) : rnd_word();
            #4;
            chk("load_cfg_ready", 64'(cfg_ready), 64'd1);
            chk("load_busy", 64'(busy), 64'd1);
            chk("load_rd_gnt", 64'(rd_gnt), 64'd0);
            chk("load_bram_we", 64'(bram_we), 64'(cfg_valid));
            chk("load_bram_en", 64'(bram_en), 64'(cfg_valid));
            if (cfg_valid) begin
                chk("load_bram_addr", 64'(bram_addr), 64'(n));
                chk("load_bram_data_in", 64'(bram_data_in), 64'(cfg_data));
                ref_mem[n] = cfg_data;
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        cfg_valid = 1'b0;
        chk("load_words_in_budget", 64'(n), 64'(target));
        if (target == TOT) begin
            chk("load_done_loaded", 64'(loaded), 64'd1);
            chk("load_done_busy", 64'(busy), 64'd0);
        end else begin
            chk("load_part_loaded", 64'(loaded), 64'd0);
            chk("load_part_busy", 64'(busy), 64'd1);
        end
    endtask

    initial begin
        logic          prev_valid;
        logic [DW-1:0] prev_data;

        for (int i = 0; i < 64; i++) mem[i] = '0;
        for (int i = 0; i < TOT; i++) ref_mem[i] = '0;

        vecs[0] = '{1'b1, 6'd0,  1'b1, 1'b1, 36'd0};
        vecs[1] = '{1'b1, 6'd1,  1'b1, 1'b1, 36'd3};
        vecs[2] = '{1'b1, 6'd53, 1'b1, 1'b1, 36'd159};
        vecs[3] = '{1'b1, 6'd60, 1'b1, 1'b0, 36'd0};
        vecs[4] = '{1'b0, 6'd2,  1'b0, 1'b0, 36'd0};
        vecs[5] = '{1'b1, 6'd54, 1'b1, 1'b0, 36'd0};
        vecs[6] = '{1'b1, 6'd63, 1'b1, 1'b0, 36'd0};
        vecs[7] = '{1'b1, 6'd10, 1'b1, 1'b1, 36'd30};

        // Reset with active-looking inputs
        rd_req    = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = rnd_word();
        #3;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n     = 1'b1;
        rd_req    = 1'b0;
        cfg_valid = 1'b0;
        #4;
        chk("idle_cfg_ready", 64'(cfg_ready), 64'd0);
        @(posedge clk); #1;

        // Full load with a ramp pattern and cfg_valid held high
        start_load();
        run_load(1'b0, 1'b1, TOT);

        // Table of reads, including out-of-range and idle rows, issued back to back
        prev_valid = 1'b0;
        prev_data  = '0;
        for (int i = 0; i < 8; i++) begin
            rd_req  = vecs[i].req;
            rd_addr = vecs[i].addr;
            #4;
            chk("vec_rd_gnt", 64'(rd_gnt), 64'(vecs[i].exp_gnt));
            chk("vec_bram_en", 64'(bram_en), 64'(vecs[i].exp_en));
            chk("vec_bram_we", 64'(bram_we), 64'd0);
            chk("vec_rd_valid", 64'(rd_valid), 64'(prev_valid));
            chk("vec_rd_data", 64'(rd_data), 64'(prev_data));
            prev_valid = vecs[i].exp_gnt;
            prev_data  = vecs[i].exp_data;
            @(posedge clk); #1;
        end
        rd_req = 1'b0;
        #4;
        chk("vec_tail_rd_valid", 64'(rd_valid), 64'(prev_valid));
        chk("vec_tail_rd_data", 64'(rd_data), 64'(prev_data));
        @(posedge clk); #1;

        // Randomized reads against the model
        prev_valid = 1'b0;
        prev_data  = '0;
        for (int i = 0; i < 300; i++) begin
            rd_req  = ($urandom_range(0, 9) < 7);
            rd_addr = AW'($urandom_range(0, 63));
            #4;
            chk("rnd_rd_gnt", 64'(rd_gnt), 64'(rd_req));
            chk("rnd_bram_en", 64'(bram_en), 64'(rd_req && (32'(rd_addr) < TOT)));
            chk("rnd_bram_we", 64'(bram_we), 64'd0);
            chk("rnd_rd_valid", 64'(rd_valid), 64'(prev_valid));
            chk("rnd_rd_data", 64'(rd_data), 64'(prev_data));
            prev_valid = rd_req;
            prev_data  = rd_req ? expect_word(rd_addr) : '0;
            @(posedge clk); #1;
        end

        // A read granted just before load_start still returns on the next cycle
        rd_req  = 1'b1;
        rd_addr = 6'd7;
        #4;
        chk("preload_rd_gnt", 64'(rd_gnt), 64'd1);
        @(posedge clk); #1;
        rd_req     = 1'b0;
        load_start = 1'b1;
        #4;
        chk("preload_rd_valid", 64'(rd_valid), 64'd1);
        chk("preload_rd_data", 64'(rd_data), 64'(ref_mem[7]));
        chk("preload_cfg_ready", 64'(cfg_ready), 64'd0);
        @(posedge clk); #1;
        load_start = 1'b0;
        chk("preload_busy", 64'(busy), 64'd1);
        chk("preload_loaded", 64'(loaded), 64'd0);
        #4;
        chk("preload_valid_gone", 64'(rd_valid), 64'd0);
        @(posedge clk); #1;

        // Random cfg_valid and random data
        run_load(1'b1, 1'b0, TOT);

        // load_start beats a same-cycle rd_req; the held request waits for the whole reload
        rd_req  = 1'b1;
        rd_addr = 6'd5;
        start_load();
        run_load(1'b1, 1'b0, TOT);
        #4;
        chk("held_rd_gnt", 64'(rd_gnt), 64'd1);
        chk("held_bram_en", 64'(bram_en), 64'd1);
        chk("held_bram_addr", 64'(bram_addr), 64'd5);
        @(posedge clk); #1;
        rd_req = 1'b0;
        #4;
        chk("held_rd_valid", 64'(rd_valid), 64'd1);
        chk("held_rd_data", 64'(rd_data), 64'(ref_mem[5]));
        @(posedge clk); #1;

        // Reset in the middle of a load, then a fresh load from address 0
        start_load();
        run_load(1'b1, 1'b0, 20);
        cfg_valid = 1'b1;
        cfg_data  = rnd_word();
        rst_n     = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst_n     = 1'b1;
        cfg_valid = 1'b0;
        #4;
        chk("postreset_cfg_ready", 64'(cfg_ready), 64'd0);
        chk("postreset_loaded", 64'(loaded), 64'd0);
        @(posedge clk); #1;
        start_load();
        run_load(1'b1, 1'b0, TOT);

        // Spot reads after the reload
        prev_valid = 1'b0;
        prev_data  = '0;
        for (int i = 0; i < 20; i++) begin
            rd_req  = 1'b1;
            rd_addr = AW'($urandom_range(0, TOT - 1));
            #4;
            chk("final_rd_gnt", 64'(rd_gnt), 64'd1);
            chk("final_rd_valid", 64'(rd_valid), 64'(prev_valid));
            chk("final_rd_data", 64'(rd_data), 64'(prev_data));
            prev_valid = 1'b1;
            prev_data  = expect_word(rd_addr);
            @(posedge clk); #1;
        end
        rd_req = 1'b0;
        #4;
        chk("final_tail_rd_data", 64'(rd_data), 64'(prev_data));
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
